// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Stall holds everything; a flush or a load-use hazard inserts an all-zero bubble.
module id_ex_reg (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic        RegDst_i,
    input  logic        ALUSrc_i,
    input  logic        MemtoReg_i,
    input  logic        RegWrite_i,
    input  logic        MemWrite_i,
    input  logic        MemRead_i,
    input  logic [1:0]  ALUOp_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [5:0]  funct_i,
    output logic        valid_o,
    output logic        RegDst_o,
    output logic        ALUSrc_o,
    output logic        MemtoReg_o,
    output logic        RegWrite_o,
    output logic        MemWrite_o,
    output logic        MemRead_o,
    output logic [1:0]  ALUOp_o,
    output logic [31:0] rs_data_o,
    output logic [31:0] rt_data_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs_addr_o,
    output logic [4:0]  rt_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic [5:0]  funct_o,
    output logic        hazard_o,
    output logic [15:0] bubble_cnt_o
);

    logic        load_use;
    logic        bubble;
    logic [15:0] bubble_cnt_q;

    // A load in EX whose destination feeds the decode-stage instruction; r0 never hazards.
    assign load_use = MemRead_o & valid_o & (rt_addr_o != 5'd0) &
                      ((rt_addr_o == rs_addr_i) | (rt_addr_o == rt_addr_i)) & valid_i;
    assign hazard_o = load_use & ~flush_i;
    assign bubble   = flush_i | load_use;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            RegDst_o   <= 1'b0;
            ALUSrc_o   <= 1'b0;
            MemtoReg_o <= 1'b0;
            RegWrite_o <= 1'b0;
            MemWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
            ALUOp_o    <= 2'b00;
            rs_data_o  <= 32'h0;
            rt_data_o  <= 32'h0;
            imm_o      <= 32'h0;
            rs_addr_o  <= 5'd0;
            rt_addr_o  <= 5'd0;
            rd_addr_o  <= 5'd0;
            funct_o    <= 6'd0;
        end else if (!stall_i) begin
            if (bubble) begin
                valid_o    <= 1'b0;
                RegDst_o   <= 1'b0;
                ALUSrc_o   <= 1'b0;
                MemtoReg_o <= 1'b0;
                RegWrite_o <= 1'b0;
                MemWrite_o <= 1'b0;
                MemRead_o  <= 1'b0;
                ALUOp_o    <= 2'b00;
                rs_data_o  <= 32'h0;
                rt_data_o  <= 32'h0;
                imm_o      <= 32'h0;
                rs_addr_o  <= 5'd0;
                rt_addr_o  <= 5'd0;
                rd_addr_o  <= 5'd0;
                funct_o    <= 6'd0;
            end else begin
                valid_o    <= valid_i;
                RegDst_o   <= RegDst_i;
                ALUSrc_o   <= ALUSrc_i;
                MemtoReg_o <= MemtoReg_i;
                RegWrite_o <= RegWrite_i;
                MemWrite_o <= MemWrite_i;
                MemRead_o  <= MemRead_i;
                ALUOp_o    <= ALUOp_i;
                rs_data_o  <= rs_data_i;
                rt_data_o  <= rt_data_i;
                imm_o      <= imm_i;
                rs_addr_o  <= rs_addr_i;
                rt_addr_o  <= rt_addr_i;
                rd_addr_o  <= rd_addr_i;
                funct_o    <= funct_i;
            end
        end
    end

    // Only hazard bubbles are counted; flush wins over load_use and does not count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_q <= 16'h0;
        end else if (!stall_i && !flush_i && load_use && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'h1;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed scenarios plus random traffic against an instruction-level model.
module tb_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic        regdst;
        logic        alusrc;
        logic        memtoreg;
        logic        regwrite;
        logic        memwrite;
        logic        memread;
        logic [1:0]  aluop;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic [5:0]  funct;
    } instr_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    instr_t      din;
    instr_t      obs;
    logic        valid_o, RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemWrite_o, MemRead_o;
    logic [1:0]  ALUOp_o;
    logic [31:0] rs_data_o, rt_data_o, imm_o;
    logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
    logic [5:0]  funct_o;
    logic        hazard_o;
    logic [15:0] bubble_cnt_o;

    instr_t m_ex;
    int     m_cnt;
    int     total = 0;
    int     bad = 0;

    always #5 clk_i = ~clk_i;

    id_ex_reg dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(din.valid), .RegDst_i(din.regdst), .ALUSrc_i(din.alusrc),
        .MemtoReg_i(din.memtoreg), .RegWrite_i(din.regwrite), .MemWrite_i(din.memwrite),
        .MemRead_i(din.memread), .ALUOp_i(din.aluop), .rs_data_i(din.rs_data),
        .rt_data_i(din.rt_data), .imm_i(din.imm), .rs_addr_i(din.rs_addr),
        .rt_addr_i(din.rt_addr), .rd_addr_i(din.rd_addr), .funct_i(din.funct),
        .valid_o(valid_o), .RegDst_o(RegDst_o), .ALUSrc_o(ALUSrc_o), .MemtoReg_o(MemtoReg_o),
        .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o),
        .ALUOp_o(ALUOp_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
        .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
        .funct_o(funct_o), .hazard_o(hazard_o), .bubble_cnt_o(bubble_cnt_o)
    );

    assign obs = {valid_o, RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemWrite_o, MemRead_o,
                  ALUOp_o, rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o, funct_o};

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Would the decode instruction read a register that the load sitting in EX is still fetching?
    function automatic logic model_hazard();
        return m_ex.valid && m_ex.memread && m_ex.rt_addr != 0 && din.valid &&
               (m_ex.rt_addr == din.rs_addr || m_ex.rt_addr == din.rt_addr);
    endfunction

    // Called at a negedge with inputs already applied; returns at the following negedge.
    task automatic step(input string tag);
        logic lu;
        #1;
        lu = model_hazard();
        chk({tag, "_hazard"}, 128'(hazard_o), 128'(lu && !flush_i));
        @(posedge clk_i);
        if (!stall_i) begin
            if (flush_i || lu) begin
                m_ex = '0;
                if (!flush_i && lu && m_cnt < 65535) m_cnt++;
            end else begin
                m_ex = din;
            end
        end
        #1;
        chk({tag, "_regs"}, 128'(obs), 128'(m_ex));
        chk({tag, "_cnt"}, 128'(bubble_cnt_o), 128'(m_cnt));
        @(negedge clk_i);
    endtask

    function automatic instr_t lw(input logic [4:0] rt);
        instr_t t = '0;
        t.valid = 1'b1; t.memread = 1'b1; t.memtoreg = 1'b1; t.regwrite = 1'b1;
        t.alusrc = 1'b1; t.rt_addr = rt; t.imm = 32'h10;
        return t;
    endfunction

    function automatic instr_t user(input logic [4:0] rs);
        instr_t t = '0;
        t.valid = 1'b1; t.regwrite = 1'b1; t.rs_addr = rs; t.rd_addr = 5'd9;
        t.rs_data = 32'hCAFE_0001;
        return t;
    endfunction

    task automatic load_use_pair(input string tag);
        din = lw(5'd8);
        step({tag, "_lw"});
        din = user(5'd8);
        step({tag, "_use"});
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        din = lw(5'd8);
        m_ex = '0; m_cnt = 0;
        #2;
        chk("reset_regs", 128'(obs), 128'(0));
        chk("reset_cnt", 128'(bubble_cnt_o), 128'(0));
        chk("reset_hazard", 128'(hazard_o), 128'(0));
        @(negedge clk_i);
        rst_i = 1'b0;

        // Plain load with one-cycle latency
        din = '0; din.valid = 1'b1; din.regwrite = 1'b1; din.aluop = 2'b10;
        din.rs_data = 32'h5; din.rd_addr = 5'd3;
        step("load");
        chk("load_fields", 128'({RegWrite_o, ALUOp_o, rs_data_o, rd_addr_o, valid_o}),
            128'({1'b1, 2'b10, 32'h5, 5'd3, 1'b1}));

        // Load-use: one bubble, then the dependent instruction goes through
        din = lw(5'd8);
        step("lu_lw");
        din = user(5'd8);
        #1;
        chk("lu_hazard_hi", 128'(hazard_o), 128'(1));
        step("lu_bubble");
        chk("lu_after_bubble", 128'({valid_o, MemRead_o, bubble_cnt_o}), 128'({1'b0, 1'b0, 16'd1}));
        step("lu_reload");
        chk("lu_loaded", 128'({valid_o, rs_addr_o}), 128'({1'b1, 5'd8}));

        // r0 destination never hazards
        din = lw(5'd0);
        step("zr_lw");
        din = user(5'd0);
        step("zr_use");
        chk("zr_cnt", 128'(bubble_cnt_o), 128'(1));

        // Flush beats hazard and is not counted; stall beats both
        din = lw(5'd8);
        step("fl_lw");
        din = user(5'd8); flush_i = 1'b1;
        step("fl_flush");
        chk("fl_cnt", 128'({valid_o, bubble_cnt_o}), 128'({1'b0, 16'd1}));
        flush_i = 1'b0; din = lw(5'd8);
        step("st_lw");
        din = user(5'd8); flush_i = 1'b1; stall_i = 1'b1;
        step("st_hold");
        chk("st_held", 128'({MemRead_o, rt_addr_o, bubble_cnt_o}), 128'({1'b1, 5'd8, 16'd1}));
        flush_i = 1'b0; stall_i = 1'b0;
        step("st_release");
        chk("st_cnt", 128'(bubble_cnt_o), 128'(2));

        // Random traffic with a narrow register range so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            din.valid    = ($urandom_range(0, 9) != 0);
            din.regdst   = 1'($urandom);
            din.alusrc   = 1'($urandom);
            din.memtoreg = 1'($urandom);
            din.regwrite = 1'($urandom);
            din.memwrite = 1'($urandom);
            din.memread  = ($urandom_range(0, 2) == 0);
            din.aluop    = 2'($urandom);
            din.rs_data  = $urandom;
            din.rt_data  = $urandom;
            din.imm      = $urandom;
            din.rs_addr  = 5'($urandom_range(0, 3));
            din.rt_addr  = 5'($urandom_range(0, 3));
            din.rd_addr  = 5'($urandom);
            din.funct    = 6'($urandom);
            stall_i      = ($urandom_range(0, 9) == 0);
            flush_i      = ($urandom_range(0, 9) == 0);
            step("rnd");
        end
        stall_i = 1'b0; flush_i = 1'b0;

        // Saturation: jump the counter near the top instead of spending ~131k cycles on bubbles
        din = '0;
        step("sat_idle");
        force dut.bubble_cnt_q = 16'hFFFC;
        #1;
        release dut.bubble_cnt_q;
        m_cnt = 65532;
        chk("sat_preload", 128'(bubble_cnt_o), 128'(16'hFFFC));
        load_use_pair("sat1");
        load_use_pair("sat2");
        chk("sat_fffe", 128'(bubble_cnt_o), 128'(16'hFFFE));
        load_use_pair("sat3");
        chk("sat_ffff", 128'(bubble_cnt_o), 128'(16'hFFFF));
        load_use_pair("sat4");
        chk("sat_hold", 128'(bubble_cnt_o), 128'(16'hFFFF));

        // Asynchronous reset between edges
        rst_i = 1'b1;
        #1;
        m_ex = '0; m_cnt = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 7; i++) load_use_pair("ar_pair");
        din = lw(5'd8);
        step("ar_lw");
        chk("ar_pre", 128'({valid_o, bubble_cnt_o}), 128'({1'b1, 16'd7}));
        din = user(5'd8);
        #2;
        rst_i = 1'b1;
        #1;
        chk("ar_regs", 128'(obs), 128'(0));
        chk("ar_cnt", 128'(bubble_cnt_o), 128'(0));
        chk("ar_hazard", 128'(hazard_o), 128'(0));
        m_ex = '0; m_cnt = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        din = user(5'd8);
        step("ar_first_edge");
        chk("ar_first_load", 128'({valid_o, rs_addr_o}), 128'({1'b1, 5'd8}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
